// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared definitions for the iterative square-root block.
//   sqrt_state_t  - controller states (IDLE, CALC, DONE)
//   root_width    - root width for an N-bit radicand
//   rem_width     - reported remainder width
//   calc_width    - signed working-remainder width inside the iteration chain
//   calc_cycles   - CALC cycles for a given N and bits-per-clock
//   cnt_width     - iteration counter width
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sqrt_state_t;

    function automatic int unsigned root_width(input int unsigned n);
        return n / 2;
    endfunction

    function automatic int unsigned rem_width(input int unsigned n);
        return n / 2 + 1;
    endfunction

    function automatic int unsigned calc_width(input int unsigned n);
        return n / 2 + 2;
    endfunction

    function automatic int unsigned calc_cycles(input int unsigned n, input int unsigned steps);
        return n / (2 * steps);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n, input int unsigned steps);
        int unsigned c;
        c = calc_cycles(n, steps);
        return (c > 1) ? $clog2(c) : 1;
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// sqrt_step: one combinational non-restoring square-root iteration.
//   pair     - next radicand bit pair, MSB pair first
//   root_in  - partial root so far
//   rem_in   - signed partial remainder (two's complement, RW+2 bits)
//   root_out - partial root with one more bit resolved
//   rem_out  - updated signed partial remainder
module sqrt_step #(
    parameter int unsigned RW = 16
) (
    input  logic [1:0]    pair,
    input  logic [RW-1:0] root_in,
    input  logic [RW+1:0] rem_in,
    output logic [RW-1:0] root_out,
    output logic [RW+1:0] rem_out
);

    logic [RW+1:0] shifted;

    always_comb begin
        shifted = (rem_in << 2) | {{RW{1'b0}}, pair};
        // Non-negative remainder subtracts 4Q+1, negative adds 4Q+3.
        if (!rem_in[RW+1]) begin
            rem_out = shifted - {root_in, 2'b01};
        end else begin
            rem_out = shifted + {root_in, 2'b11};
        end
        root_out = (root_in << 1) | {{(RW-1){1'b0}}, ~rem_out[RW+1]};
    end

endmodule

// File: rtl/sqrt_iterative.sv
// sqrt_iterative: multi-cycle unsigned integer square root, STEPS root bits per clock.
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   - radicand handshake, in_data is the N-bit radicand
//   out_valid/out_ready - result handshake; out_root (N/2 bits, truncated or
//                         rounded per ROUND), out_rem (N/2+1 bits, truncating remainder)
//   busy                - high whenever an operation is in flight or waiting
module sqrt_iterative
    import sqrt_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned STEPS = 1,
    parameter int unsigned ROUND = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N/2-1:0] out_root,
    output logic [N/2:0]   out_rem,
    output logic           busy
);

    localparam int unsigned RW     = root_width(N);
    localparam int unsigned CW     = calc_width(N);
    localparam int unsigned CYCLES = calc_cycles(N, STEPS);
    localparam int unsigned CNT_W  = cnt_width(N, STEPS);

    sqrt_state_t state, state_nxt;

    logic [N-1:0]     rad_q;
    logic [RW-1:0]    root_q;
    logic [CW-1:0]    rem_q;
    logic [CNT_W-1:0] cnt_q;

    logic [RW-1:0] root_c [STEPS+1];
    logic [CW-1:0] rem_c  [STEPS+1];
    logic [CW-1:0] rem_fix;
    logic          accept;
    logic          round_up;

    assign root_c[0] = root_q;
    assign rem_c[0]  = rem_q;

    for (genvar s = 0; s < STEPS; s++) begin : g_step
        sqrt_step #(.RW(RW)) u_step (
            .pair     (rad_q[N-1-2*s -: 2]),
            .root_in  (root_c[s]),
            .rem_in   (rem_c[s]),
            .root_out (root_c[s+1]),
            .rem_out  (rem_c[s+1])
        );
    end

    // Negative final remainder is restored by adding 2Q+1 in the same cycle.
    assign rem_fix = rem_c[STEPS][CW-1] ? rem_c[STEPS] + {1'b0, root_c[STEPS], 1'b1}
                                        : rem_c[STEPS];

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        out_root  = '0;
        out_rem   = '0;
        // Rounding up is needed exactly when the truncating remainder exceeds the root.
        round_up  = (ROUND != 0) && ({1'b0, root_q} < rem_q[RW:0]) && (root_q != '1);
        case (state)
            IDLE: begin
                in_ready = !reset;
                busy     = 1'b0;
                if (accept) state_nxt = CALC;
            end
            CALC: begin
                if (cnt_q == '0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                out_root  = root_q + RW'(round_up);
                out_rem   = rem_q[RW:0];
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rad_q  <= '0;
            root_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rad_q  <= in_data;
                        root_q <= '0;
                        rem_q  <= '0;
                        cnt_q  <= CNT_W'(CYCLES - 1);
                    end
                end
                CALC: begin
                    rad_q  <= rad_q << (2 * STEPS);
                    root_q <= root_c[STEPS];
                    if (cnt_q == '0) begin
                        rem_q <= rem_fix;
                    end else begin
                        rem_q <= rem_c[STEPS];
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        rad_q  <= '0;
                        root_q <= '0;
                        rem_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sqrt_iterative.md
SQRT_ITERATIVE -- requirements
Module: sqrt_iterative

Interface
REQ-001 Parameter N, default 32: radicand width; SHALL be even and >= 4.
REQ-002 Parameter STEPS, default 1: root bits resolved per clock; SHALL divide N/2 exactly.
REQ-003 Parameter ROUND, default 0: 0 = truncated root, 1 = round-to-nearest root.
REQ-004 clk  input  1  single rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  radicand on in_data is offered.
REQ-007 in_ready  output  1  block accepts a radicand this cycle.
REQ-008 in_data  input  N  unsigned radicand.
REQ-009 out_valid  output  1  result on out_root/out_rem is valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out_root  output  N/2  unsigned square root (truncated or rounded per ROUND).
REQ-012 out_rem  output  N/2+1  unsigned remainder in_data - floor(sqrt(in_data))^2.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 Three states SHALL exist: IDLE, CALC, DONE.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready, capture in_data, clear partial root/remainder, load iteration counter with N/(2*STEPS)-1, go to CALC.
REQ-016 CALC: in_ready=0; each cycle perform STEPS non-restoring iterations, MSB radicand pair first; counter decrements by 1 per cycle.
REQ-017 CALC SHALL last exactly N/(2*STEPS) cycles; on the cycle counter==0, go to DONE.
REQ-018 Remainder datapath SHALL be N/2+2 bits signed; final negative remainder SHALL be corrected by adding (2*root+1) before entering DONE, with no extra cycle.
REQ-019 DONE: out_valid=1; out_root and out_rem stable until out_valid&&out_ready, then go to IDLE.
REQ-020 Latency: handshake accept at edge k -> out_valid first high after edge k+N/(2*STEPS); N=32, STEPS=1 gives 16 cycles.
REQ-021 No input accepted in CALC or DONE; in_valid during those states SHALL be ignored with no side effect.
REQ-022 out_valid and out_ready both high SHALL return to IDLE; in_ready asserts the following cycle, not the same cycle.
REQ-023 ROUND=1: if truncating remainder > truncated root, out_root = root+1, saturating at all-ones; out_rem always reports the truncating remainder.
REQ-024 out_root and out_rem SHALL read 0 outside DONE.
REQ-025 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-026 reset high SHALL immediately force IDLE, in_ready=1 (after release), out_valid=0, busy=0, out_root=0, out_rem=0, counter=0, all datapath registers 0.
REQ-027 reset asserted mid-CALC or in DONE SHALL discard the operation; no out_valid for it after release.
REQ-028 While reset is high, in_ready SHALL be 0.

Structure
REQ-029 Package sqrt_pkg SHALL hold the state enum (IDLE, CALC, DONE) and width helper constants/functions (root width, remainder width, cycle count).
REQ-030 Sub-module sqrt_step SHALL implement one combinational non-restoring iteration (bit pair, root, remainder in -> root, remainder out), instantiated STEPS times in a chain.
REQ-031 Top level SHALL hold only the FSM, counter, registers, correction and rounding.

Verification
REQ-032 N=32, STEPS=1, ROUND=0: in_data=0 -> out_root=0, out_rem=0, out_valid 16 cycles after accept.
REQ-033 in_data=0xFFFFFFFF -> out_root=0xFFFF, out_rem=0x1FFFE; ROUND=1 -> out_root saturates at 0xFFFF.
REQ-034 in_data=1000000 -> 1000 rem 0; in_data=24 -> 4 rem 8 (ROUND=0), 5 rem 8 (ROUND=1).
REQ-035 Backpressure: out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0, second in_valid ignored; release -> IDLE next cycle.
REQ-036 Assert reset at CALC cycle 7 -> immediate IDLE/out_valid=0; next accepted 49 -> 7 rem 0 with normal latency.
REQ-037 N=16, STEPS=4: random 10k operands vs reference model, latency 2 cycles in CALC each.
